hazard_stall_ctrl: RTL and testbench
====================================

// Module: hazard_stall_ctrl
// PURPOSE
//  Drives the hold/flush side of the ID/EX pipeline register interface.
//  Watches the instruction held in ID/EX (rd, mem-read, reg-write) against the
//  instruction being decoded in ID (rs1/rs2). Generates load-use stalls, branch
//  flushes and the global memory BUSYWAIT freeze for PC, IF/ID and ID/EX.
//  Sits beside the decode stage; outputs go straight to the pipeline registers.
// PARAMETERS
//  LOAD_USE_BUBBLES  1   bubbles inserted per load-use hazard; legal range 1..3
//  CNT_W             16  width of the performance counters
// PORTS
//  CLK              in   1      clock, rising edge
//  RESET            in   1      synchronous, active-high
//  ID_R_ADDR1       in   5      rs1 of the instruction in ID
//  ID_R_ADDR2       in   5      rs2 of the instruction in ID
//  ID_USES_RS1      in   1      the ID instruction reads rs1
//  ID_USES_RS2      in   1      the ID instruction reads rs2
//  EX_RD            in   5      rd field from ID/EX (instruction bits [11:7])
//  EX_MEM_READ      in   3      ID/EX mem-read code; 3'b000 = not a load
//  EX_REG_WRITE_EN  in   1      ID/EX register-write enable
//  EX_BRANCH_TAKEN  in   1      branch/jump in EX resolved taken this cycle
//  IMEM_BUSYWAIT    in   1      instruction memory busy
//  DMEM_BUSYWAIT    in   1      data memory busy
//  PIPE_BUSYWAIT    out  1      freeze all pipeline registers and PC
//  PC_STALL         out  1      hold PC
//  IF_ID_STALL      out  1      hold IF/ID
//  IF_ID_FLUSH      out  1      load NOP into IF/ID
//  ID_EX_BUBBLE     out  1      load NOP into ID/EX (all control fields 0)
//  STALL_COUNT      out  CNT_W  load-use bubble cycles, saturating
//  FLUSH_COUNT      out  CNT_W  branch flush events, saturating
// BEHAVIOUR
//  - FSM states: RUN, LOAD_STALL. Down-counter bcnt, 2 bits.
//  - Control outputs are combinational from state + inputs. State and counters
//    update on the CLK rising edge.
//  - Reset: state=RUN, bcnt=0, STALL_COUNT=0, FLUSH_COUNT=0. While RESET=1,
//    all control outputs are 0, including PIPE_BUSYWAIT.
//  - hz = (EX_MEM_READ!=0) & EX_REG_WRITE_EN & (EX_RD!=0) &
//    ((ID_USES_RS1 & ID_R_ADDR1==EX_RD) | (ID_USES_RS2 & ID_R_ADDR2==EX_RD)).
//  - Priority 1, memory busywait:
//    * PIPE_BUSYWAIT = IMEM_BUSYWAIT | DMEM_BUSYWAIT, zero latency.
//    * While it is 1, every other control output is 0.
//    * State, bcnt and both counters hold.
//  - Priority 2, branch taken (EX_BRANCH_TAKEN=1, no busywait):
//    * IF_ID_FLUSH=1 and ID_EX_BUBBLE=1 for exactly that cycle.
//    * PC_STALL=0 and IF_ID_STALL=0.
//    * Next state is RUN and bcnt=0; this aborts any LOAD_STALL.
//    * FLUSH_COUNT increments by 1.
//  - Priority 3, RUN with hz=1:
//    * PC_STALL=1, IF_ID_STALL=1, ID_EX_BUBBLE=1.
//    * STALL_COUNT increments by 1.
//    * If LOAD_USE_BUBBLES>1: next state LOAD_STALL, bcnt=LOAD_USE_BUBBLES-2.
//  - LOAD_STALL:
//    * Same three outputs asserted; STALL_COUNT increments every cycle.
//    * hz is not re-evaluated, because the EX stage holds a bubble.
//    * When bcnt=0, next state is RUN; otherwise bcnt decrements.
//  - Total bubble cycles per hazard = LOAD_USE_BUBBLES, excluding busywait cycles.
//  - Counters saturate at all-ones and never wrap.
//  - RESET during LOAD_STALL returns to RUN on that edge; the stall is dropped.
// TESTING
//  1. RESET=1 for 2 cycles -> all outputs 0, both counters 0, state RUN.
//  2. EX_MEM_READ=3'b010, REG_WRITE_EN=1, EX_RD=5, ID_R_ADDR2=5, USES_RS2=1,
//     default params -> exactly 1 cycle of PC_STALL/IF_ID_STALL/ID_EX_BUBBLE;
//     STALL_COUNT=1.
//  3. Same hazard with EX_RD=0, or EX_MEM_READ=0 -> no stall asserted.
//  4. LOAD_USE_BUBBLES=3, hazard, DMEM_BUSYWAIT=1 on the 2nd bubble cycle for
//     4 cycles -> PIPE_BUSYWAIT=1 for 4 cycles, other outputs 0; then 2 more
//     bubble cycles; STALL_COUNT=3.
//  5. EX_BRANCH_TAKEN=1 together with hz=1 -> IF_ID_FLUSH=1, ID_EX_BUBBLE=1,
//     PC_STALL=0; FLUSH_COUNT=1, STALL_COUNT=0.
//  6. CNT_W=4, 20 branch flushes -> FLUSH_COUNT stops at 4'hF.

Source files
------------

// File: rtl/hazard_stall_ctrl_if.sv
// Signal bundle between the decode-stage hazard controller and the pipeline registers.
// The slave modport is the controller; the master modport is the pipeline side.
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_idRAddr1;
  logic [4:0]       i_idRAddr2;
  logic             i_idUsesRs1;
  logic             i_idUsesRs2;
  logic [4:0]       i_exRd;
  logic [2:0]       i_exMemRead;
  logic             i_exRegWriteEn;
  logic             i_exBranchTaken;
  logic             i_imemBusywait;
  logic             i_dmemBusywait;
  logic             o_pipeBusywait;
  logic             o_pcStall;
  logic             o_ifIdStall;
  logic             o_ifIdFlush;
  logic             o_idExBubble;
  logic [CNT_W-1:0] o_stallCount;
  logic [CNT_W-1:0] o_flushCount;

  modport master (
    output i_idRAddr1, i_idRAddr2, i_idUsesRs1, i_idUsesRs2,
    output i_exRd, i_exMemRead, i_exRegWriteEn, i_exBranchTaken,
    output i_imemBusywait, i_dmemBusywait,
    input  o_pipeBusywait, o_pcStall, o_ifIdStall, o_ifIdFlush, o_idExBubble,
    input  o_stallCount, o_flushCount
  );

  modport slave (
    input  i_idRAddr1, i_idRAddr2, i_idUsesRs1, i_idUsesRs2,
    input  i_exRd, i_exMemRead, i_exRegWriteEn, i_exBranchTaken,
    input  i_imemBusywait, i_dmemBusywait,
    output o_pipeBusywait, o_pcStall, o_ifIdStall, o_ifIdFlush, o_idExBubble,
    output o_stallCount, o_flushCount
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Load-use stall, branch flush and memory busywait freeze control for PC, IF/ID and ID/EX.
// Priority: memory busywait, then taken branch, then load-use stall.
module hazard_stall_ctrl #(
  parameter int LOAD_USE_BUBBLES = 1,
  parameter int CNT_W            = 16
) (
  input logic                 CLK,
  input logic                 RESET,
  hazard_stall_ctrl_if.slave  bus
);

  typedef enum logic {
    RUN,
    LOAD_STALL
  } state_t;

  // A single bubble needs no extra state; longer stalls count down the remaining cycles.
  localparam bit         MULTI_BUBBLE = (LOAD_USE_BUBBLES > 1);
  localparam logic [1:0] BCNT_INIT    = MULTI_BUBBLE ? 2'(LOAD_USE_BUBBLES - 2) : 2'd0;

  state_t           r_state;
  state_t           w_nextState;
  logic [1:0]       r_bcnt;
  logic [1:0]       w_nextBcnt;
  logic [CNT_W-1:0] r_stallCount;
  logic [CNT_W-1:0] r_flushCount;
  logic             w_busy;
  logic             w_rs1Match;
  logic             w_rs2Match;
  logic             w_hz;
  logic             w_incStall;
  logic             w_incFlush;
  logic             w_pipeBusywait;
  logic             w_pcStall;
  logic             w_ifIdStall;
  logic             w_ifIdFlush;
  logic             w_idExBubble;

  assign w_busy     = bus.i_imemBusywait | bus.i_dmemBusywait;
  assign w_rs1Match = bus.i_idUsesRs1 & (bus.i_idRAddr1 == bus.i_exRd);
  assign w_rs2Match = bus.i_idUsesRs2 & (bus.i_idRAddr2 == bus.i_exRd);
  assign w_hz       = (bus.i_exMemRead != 3'b000) & bus.i_exRegWriteEn &
                      (bus.i_exRd != 5'd0) & (w_rs1Match | w_rs2Match);

  always_comb begin
    w_nextState    = r_state;
    w_nextBcnt     = r_bcnt;
    w_incStall     = 1'b0;
    w_incFlush     = 1'b0;
    w_pipeBusywait = 1'b0;
    w_pcStall      = 1'b0;
    w_ifIdStall    = 1'b0;
    w_ifIdFlush    = 1'b0;
    w_idExBubble   = 1'b0;
    if (RESET) begin
      w_nextState = RUN;
      w_nextBcnt  = 2'd0;
    end else if (w_busy) begin
      w_pipeBusywait = 1'b1;
    end else if (bus.i_exBranchTaken) begin
      w_ifIdFlush  = 1'b1;
      w_idExBubble = 1'b1;
      w_incFlush   = 1'b1;
      w_nextState  = RUN;
      w_nextBcnt   = 2'd0;
    end else begin
      unique case (r_state)
        RUN: begin
          if (w_hz) begin
            w_pcStall    = 1'b1;
            w_ifIdStall  = 1'b1;
            w_idExBubble = 1'b1;
            w_incStall   = 1'b1;
            if (MULTI_BUBBLE) begin
              w_nextState = LOAD_STALL;
              w_nextBcnt  = BCNT_INIT;
            end
          end
        end
        LOAD_STALL: begin
          // The EX stage holds a bubble here, so the hazard term is meaningless and ignored.
          w_pcStall    = 1'b1;
          w_ifIdStall  = 1'b1;
          w_idExBubble = 1'b1;
          w_incStall   = 1'b1;
          if (r_bcnt == 2'd0) begin
            w_nextState = RUN;
          end else begin
            w_nextBcnt = r_bcnt - 2'd1;
          end
        end
        default: begin
          w_nextState = RUN;
          w_nextBcnt  = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state <= RUN;
      r_bcnt  <= 2'd0;
    end else begin
      r_state <= w_nextState;
      r_bcnt  <= w_nextBcnt;
    end
  end

  // Performance counters stick at all-ones rather than wrapping.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stallCount <= '0;
      r_flushCount <= '0;
    end else begin
      if (w_incStall && (r_stallCount != {CNT_W{1'b1}})) begin
        r_stallCount <= r_stallCount + 1'b1;
      end
      if (w_incFlush && (r_flushCount != {CNT_W{1'b1}})) begin
        r_flushCount <= r_flushCount + 1'b1;
      end
    end
  end

  assign bus.o_pipeBusywait = w_pipeBusywait;
  assign bus.o_pcStall      = w_pcStall;
  assign bus.o_ifIdStall    = w_ifIdStall;
  assign bus.o_ifIdFlush    = w_ifIdFlush;
  assign bus.o_idExBubble   = w_idExBubble;
  assign bus.o_stallCount   = r_stallCount;
  assign bus.o_flushCount   = r_flushCount;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed scoreboard bench for hazard_stall_ctrl: default, 3-bubble and 4-bit-counter instances.
module tb_hazard_stall_ctrl;

  typedef struct packed {
    logic [4:0] a1;
    logic [4:0] a2;
    logic       u1;
    logic       u2;
    logic [4:0] rd;
    logic [2:0] mr;
    logic       we;
    logic       br;
    logic       im;
    logic       dm;
  } stim_t;

  typedef struct {
    int          dut;
    string       tag;
    logic [4:0]  ctrl;
    logic [15:0] sc;
    logic [15:0] fc;
  } exp_t;

  logic  CLK = 1'b0;
  logic  RESET;
  stim_t sA, sB, sC;
  exp_t  sbQ[$];
  int    passCount  = 0;
  int    failCount  = 0;
  int    totalCount = 0;

  hazard_stall_ctrl_if #(.CNT_W(16)) ifA ();
  hazard_stall_ctrl_if #(.CNT_W(16)) ifB ();
  hazard_stall_ctrl_if #(.CNT_W(4))  ifC ();

  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(16)) dutA (.CLK(CLK), .RESET(RESET), .bus(ifA));
  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(3), .CNT_W(16)) dutB (.CLK(CLK), .RESET(RESET), .bus(ifB));
  hazard_stall_ctrl #(.LOAD_USE_BUBBLES(1), .CNT_W(4))  dutC (.CLK(CLK), .RESET(RESET), .bus(ifC));

  assign {ifA.i_idRAddr1, ifA.i_idRAddr2, ifA.i_idUsesRs1, ifA.i_idUsesRs2, ifA.i_exRd, ifA.i_exMemRead,
          ifA.i_exRegWriteEn, ifA.i_exBranchTaken, ifA.i_imemBusywait, ifA.i_dmemBusywait} = sA;
  assign {ifB.i_idRAddr1, ifB.i_idRAddr2, ifB.i_idUsesRs1, ifB.i_idUsesRs2, ifB.i_exRd, ifB.i_exMemRead,
          ifB.i_exRegWriteEn, ifB.i_exBranchTaken, ifB.i_imemBusywait, ifB.i_dmemBusywait} = sB;
  assign {ifC.i_idRAddr1, ifC.i_idRAddr2, ifC.i_idUsesRs1, ifC.i_idUsesRs2, ifC.i_exRd, ifC.i_exMemRead,
          ifC.i_exRegWriteEn, ifC.i_exBranchTaken, ifC.i_imemBusywait, ifC.i_dmemBusywait} = sC;

  always #5 CLK = ~CLK;

  // ctrl vector order: {PIPE_BUSYWAIT, PC_STALL, IF_ID_STALL, IF_ID_FLUSH, ID_EX_BUBBLE}
  localparam logic [4:0] C_NONE  = 5'b00000;
  localparam logic [4:0] C_STALL = 5'b01101;
  localparam logic [4:0] C_FLUSH = 5'b00011;
  localparam logic [4:0] C_BUSY  = 5'b10000;

  function automatic stim_t mk(input logic [4:0] a1, input logic [4:0] a2, input logic u1, input logic u2,
                               input logic [4:0] rd, input logic [2:0] mr, input logic we, input logic br,
                               input logic im, input logic dm);
    stim_t s;
    s = '{a1: a1, a2: a2, u1: u1, u2: u2, rd: rd, mr: mr, we: we, br: br, im: im, dm: dm};
    return s;
  endfunction

  task automatic applyStimulus(input int d, input string tag, input stim_t s,
                               input logic [4:0] ctrl, input logic [15:0] sc, input logic [15:0] fc);
    exp_t e;
    case (d)
      0:       sA = s;
      1:       sB = s;
      default: sC = s;
    endcase
    e.dut  = d;
    e.tag  = tag;
    e.ctrl = ctrl;
    e.sc   = sc;
    e.fc   = fc;
    sbQ.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [4:0]  actCtrl;
    logic [15:0] actSc;
    logic [15:0] actFc;
    @(negedge CLK);
    e = sbQ.pop_front();
    case (e.dut)
      0: begin
        actCtrl = {ifA.o_pipeBusywait, ifA.o_pcStall, ifA.o_ifIdStall, ifA.o_ifIdFlush, ifA.o_idExBubble};
        actSc   = ifA.o_stallCount;
        actFc   = ifA.o_flushCount;
      end
      1: begin
        actCtrl = {ifB.o_pipeBusywait, ifB.o_pcStall, ifB.o_ifIdStall, ifB.o_ifIdFlush, ifB.o_idExBubble};
        actSc   = ifB.o_stallCount;
        actFc   = ifB.o_flushCount;
      end
      default: begin
        actCtrl = {ifC.o_pipeBusywait, ifC.o_pcStall, ifC.o_ifIdStall, ifC.o_ifIdFlush, ifC.o_idExBubble};
        actSc   = {12'd0, ifC.o_stallCount};
        actFc   = {12'd0, ifC.o_flushCount};
      end
    endcase
    totalCount++;
    assert (actCtrl === e.ctrl) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s ctrl: got %b expected %b", e.tag, actCtrl, e.ctrl);
    end
    totalCount++;
    assert (actSc === e.sc) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s stallCount: got %0d expected %0d", e.tag, actSc, e.sc);
    end
    totalCount++;
    assert (actFc === e.fc) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s flushCount: got %0d expected %0d", e.tag, actFc, e.fc);
    end
    @(posedge CLK);
    #1;
  endtask

  task automatic step(input int d, input string tag, input stim_t s,
                      input logic [4:0] ctrl, input logic [15:0] sc, input logic [15:0] fc);
    applyStimulus(d, tag, s, ctrl, sc, fc);
    checkOutput();
  endtask

  initial begin
    stim_t idle, ldRs2, ldRs1, ldRs1NoUse, rdZero, notLoad, noWrite, br, brLd, busyAll, dmemOnly, dmemIdle;
    idle       = '0;
    ldRs2      = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    ldRs1      = mk(5'd7, 5'd0, 1'b1, 1'b0, 5'd7, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    ldRs1NoUse = mk(5'd7, 5'd0, 1'b0, 1'b0, 5'd7, 3'b100, 1'b1, 1'b0, 1'b0, 1'b0);
    rdZero     = mk(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    notLoad    = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
    noWrite    = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0);
    br         = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0);
    brLd       = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    busyAll    = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b010, 1'b1, 1'b1, 1'b1, 1'b0);
    dmemOnly   = mk(5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 3'b010, 1'b1, 1'b0, 1'b0, 1'b1);
    dmemIdle   = mk(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1);

    RESET = 1'b1;
    sA = '0;
    sB = '0;
    sC = '0;
    @(posedge CLK);
    #1;

    // Reset holds every control output low, even with busywait and branch requested.
    step(0, "resetA1", busyAll, C_NONE, 16'd0, 16'd0);
    step(0, "resetA2", brLd, C_NONE, 16'd0, 16'd0);
    RESET = 1'b0;

    // Default instance: single-bubble load-use and the hazard qualifiers.
    step(0, "loadUseRs2", ldRs2, C_STALL, 16'd0, 16'd0);
    step(0, "afterStall", idle, C_NONE, 16'd1, 16'd0);
    step(0, "loadUseRs1", ldRs1, C_STALL, 16'd1, 16'd0);
    step(0, "rs1NotUsed", ldRs1NoUse, C_NONE, 16'd2, 16'd0);
    step(0, "rdZero", rdZero, C_NONE, 16'd2, 16'd0);
    step(0, "notLoad", notLoad, C_NONE, 16'd2, 16'd0);
    step(0, "noRegWrite", noWrite, C_NONE, 16'd2, 16'd0);
    step(0, "branchOverHz", brLd, C_FLUSH, 16'd2, 16'd0);
    step(0, "afterBranch", idle, C_NONE, 16'd2, 16'd1);
    step(0, "imemBusyTop", busyAll, C_BUSY, 16'd2, 16'd1);
    step(0, "dmemBusyHz", dmemOnly, C_BUSY, 16'd2, 16'd1);
    step(0, "afterBusy", idle, C_NONE, 16'd2, 16'd1);

    // Three-bubble instance: busywait freezes the stall mid-way.
    step(1, "b3Bubble1", ldRs2, C_STALL, 16'd0, 16'd0);
    for (int i = 0; i < 4; i++) begin
      step(1, "b3Busy", dmemIdle, C_BUSY, 16'd1, 16'd0);
    end
    step(1, "b3Bubble2", idle, C_STALL, 16'd1, 16'd0);
    step(1, "b3Bubble3", idle, C_STALL, 16'd2, 16'd0);
    step(1, "b3Done", idle, C_NONE, 16'd3, 16'd0);

    // Reset mid-stall drops the remaining bubbles.
    step(1, "b3RstStall", ldRs2, C_STALL, 16'd3, 16'd0);
    RESET = 1'b1;
    step(1, "b3InReset", idle, C_NONE, 16'd4, 16'd0);
    RESET = 1'b0;
    step(1, "b3PostReset", idle, C_NONE, 16'd0, 16'd0);

    // A taken branch aborts an in-progress stall.
    step(1, "b3AbortHz", ldRs2, C_STALL, 16'd0, 16'd0);
    step(1, "b3AbortBr", br, C_FLUSH, 16'd1, 16'd0);
    step(1, "b3Aborted", idle, C_NONE, 16'd1, 16'd1);

    // Four-bit flush counter saturates at 15.
    for (int i = 0; i < 20; i++) begin
      step(2, "satFlush", br, C_FLUSH, 16'd0, (i < 15) ? 16'(i) : 16'd15);
    end
    step(2, "satHold", idle, C_NONE, 16'd0, 16'd15);

    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
